scan_mux: RTL and testbench

Registered N-channel, W-bit multiplexer built around a parametrised one-hot decoder. Operates in manual-select or auto-scan (round-robin) mode. Captures one channel word per accepted transfer into an output holding register with a valid/ready handshake, and returns a one-hot acknowledge to the source channel. Sits between a bank of producer channels and a single downstream consumer.

---
 rtl/scan_mux_pkg.sv | 11 +
 rtl/dec_n.sv | 15 +
 rtl/scan_mux.sv | 72 +++++++
 tb/tb_scan_mux.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/scan_mux_pkg.sv
// scan_mux_pkg: mode encodings and round-robin pointer helper shared by the scan_mux slice.
package scan_mux_pkg;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_AUTO   = 1'b1;

    function automatic int ptr_next(input int p, input int n);
        return (p == n - 1) ? 0 : p + 1;
    endfunction

endpackage

// File: rtl/dec_n.sv
// dec_n: SW-to-N one-hot decoder with enable; codes >= N decode to all zeros.
module dec_n #(
    parameter int N  = 8,
    parameter int SW = $clog2(N)
) (
    input  logic [SW-1:0] w,
    input  logic          En,
    output logic [N-1:0]  y
);

    for (genvar k = 0; k < N; k++) begin : g_dec
        assign y[k] = En && (w == SW'(k));
    end

endmodule

// File: rtl/scan_mux.sv
// scan_mux: registered N-channel mux with manual select or round-robin auto-scan,
// valid/ready output holding register and one-hot acknowledge to the loaded channel.
module scan_mux
    import scan_mux_pkg::*;
#(
    parameter int N  = 8,
    parameter int W  = 8,
    parameter int SW = $clog2(N)
) (
    input  logic            Clock,
    input  logic            Resetn,
    input  logic            En,
    input  logic            mode,
    input  logic [SW-1:0]   s,
    input  logic [N*W-1:0]  w,
    input  logic [N-1:0]    wv,
    output logic [N-1:0]    ack,
    output logic [W-1:0]    f,
    output logic            fv,
    input  logic            fr,
    output logic [SW-1:0]   sel
);

    localparam logic [SW:0] N_LIM = (SW + 1)'(N);

    logic [SW-1:0] ptr;
    logic [N-1:0]  y;
    logic [W-1:0]  d;
    logic          slot_free, load, s_ok, ptr_valid;

    assign sel       = (mode == MODE_AUTO) ? ptr : s;
    assign slot_free = !fv || fr;
    assign load      = |(y & wv) && slot_free;
    assign ack       = load ? y : '0;
    assign s_ok      = {1'b0, s} < N_LIM;
    assign ptr_valid = |(wv & (N'(1) << ptr));

    dec_n #(.N(N), .SW(SW)) u_dec (
        .w  (sel),
        .En (En),
        .y  (y)
    );

    // y is one-hot or zero, so AND-OR selection never mixes channels
    always_comb begin
        d = '0;
        for (int k = 0; k < N; k++) d = d | ({W{y[k]}} & w[k*W +: W]);
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            f  <= '0;
            fv <= 1'b0;
        end else if (load) begin
            f  <= d;
            fv <= 1'b1;
        end else if (fv && fr) begin
            fv <= 1'b0;
        end
    end

    // manual mode tracks s so auto-scan resumes at the last manual channel
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn)
            ptr <= '0;
        else if (En)
            ptr <= (mode == MODE_AUTO)
                 ? ((load || !ptr_valid) ? SW'(ptr_next(int'(ptr), N)) : ptr)
                 : (s_ok ? s : '0);
    end

endmodule

// File: tb/tb_scan_mux.sv
// tb_scan_mux: directed checks of scan_mux at N=8 plus an N=6 instance for out-of-range select.
module tb_scan_mux;

    logic        Clock = 1'b0, Resetn = 1'b0, En = 1'b1, mode = 1'b0, fr = 1'b1;
    logic [2:0]  s = '0;
    logic [63:0] w = '0;
    logic [7:0]  wv = '0;
    logic [7:0]  ack, f;
    logic        fv;
    logic [2:0]  sel;
    logic [47:0] w_b = '0;
    logic [5:0]  wv_b = '0;
    logic [5:0]  ack_b;
    logic [7:0]  f_b;
    logic        fv_b;
    logic [2:0]  sel_b;
    int          pass_cnt = 0, total = 0;

    always #5 Clock = ~Clock;

    scan_mux #(.N(8), .W(8)) dut (
        .Clock(Clock), .Resetn(Resetn), .En(En), .mode(mode), .s(s), .w(w), .wv(wv),
        .ack(ack), .f(f), .fv(fv), .fr(fr), .sel(sel)
    );

    scan_mux #(.N(6), .W(8)) dut_b (
        .Clock(Clock), .Resetn(Resetn), .En(En), .mode(mode), .s(s), .w(w_b), .wv(wv_b),
        .ack(ack_b), .f(f_b), .fv(fv_b), .fr(fr), .sel(sel_b)
    );

    task automatic test_reset;
        #1;
        total++; if (f !== 8'h00) $display("FAIL reset_f got %h want 00", f); else pass_cnt++;
        total++; if (fv !== 1'b0) $display("FAIL reset_fv got %b want 0", fv); else pass_cnt++;
        total++; if (ack !== 8'h00) $display("FAIL reset_ack got %h want 00", ack); else pass_cnt++;
        @(negedge Clock); Resetn = 1'b1;
    endtask

    task automatic test_manual;
        @(negedge Clock);
        mode = 1'b0; s = 3'd5; wv = 8'h20; w[5*8 +: 8] = 8'hA5; fr = 1'b1;
        #1;
        total++; if (ack !== 8'h20) $display("FAIL manual_ack got %h want 20", ack); else pass_cnt++;
        total++; if (sel !== 3'd5) $display("FAIL manual_sel got %0d want 5", sel); else pass_cnt++;
        @(negedge Clock);
        total++; if (f !== 8'hA5) $display("FAIL manual_f got %h want a5", f); else pass_cnt++;
        total++; if (fv !== 1'b1) $display("FAIL manual_fv got %b want 1", fv); else pass_cnt++;
    endtask

    task automatic test_backpressure;
        fr = 1'b0; w[5*8 +: 8] = 8'h3C;
        for (int i = 0; i < 4; i++) begin
            #1;
            total++; if (ack !== 8'h00) $display("FAIL bp_ack[%0d] got %h want 00", i, ack); else pass_cnt++;
            @(negedge Clock);
            total++; if (f !== 8'hA5 || fv !== 1'b1) $display("FAIL bp_hold[%0d] got f=%h fv=%b want a5/1", i, f, fv); else pass_cnt++;
        end
        fr = 1'b1;
        #1;
        total++; if (ack !== 8'h20) $display("FAIL bp_release_ack got %h want 20", ack); else pass_cnt++;
        @(negedge Clock);
        total++; if (f !== 8'h3C || fv !== 1'b1) $display("FAIL bp_release_f got f=%h fv=%b want 3c/1", f, fv); else pass_cnt++;
        wv = 8'h00;
        @(negedge Clock);
        total++; if (f !== 8'h3C || fv !== 1'b0) $display("FAIL bp_drain got f=%h fv=%b want 3c/0", f, fv); else pass_cnt++;
    endtask

    task automatic test_auto_wrap;
        s = 3'd6; wv = 8'h00;
        @(negedge Clock);
        mode = 1'b1; wv = 8'b0000_0101; w[0 +: 8] = 8'h11; w[2*8 +: 8] = 8'h22; fr = 1'b1;
        #1;
        total++; if (sel !== 3'd6 || ack !== 8'h00) $display("FAIL auto_p6 got sel=%0d ack=%h want 6/00", sel, ack); else pass_cnt++;
        @(negedge Clock);
        total++; if (sel !== 3'd7 || ack !== 8'h00) $display("FAIL auto_p7 got sel=%0d ack=%h want 7/00", sel, ack); else pass_cnt++;
        @(negedge Clock);
        total++; if (sel !== 3'd0 || ack !== 8'h01) $display("FAIL auto_p0 got sel=%0d ack=%h want 0/01", sel, ack); else pass_cnt++;
        @(negedge Clock);
        total++; if (sel !== 3'd1 || ack !== 8'h00 || f !== 8'h11 || fv !== 1'b1) $display("FAIL auto_p1 got sel=%0d ack=%h f=%h fv=%b want 1/00/11/1", sel, ack, f, fv); else pass_cnt++;
        @(negedge Clock);
        total++; if (sel !== 3'd2 || ack !== 8'h04) $display("FAIL auto_p2 got sel=%0d ack=%h want 2/04", sel, ack); else pass_cnt++;
        @(negedge Clock);
        total++; if (f !== 8'h22 || sel !== 3'd3) $display("FAIL auto_load2 got f=%h sel=%0d want 22/3", f, sel); else pass_cnt++;
        wv = 8'h00; mode = 1'b0; s = 3'd0;
        @(negedge Clock);
    endtask

    task automatic test_out_of_range;
        mode = 1'b0; s = 3'd2; wv_b = 6'h3F; w_b[2*8 +: 8] = 8'h5A; fr = 1'b0;
        @(negedge Clock);
        total++; if (f_b !== 8'h5A || fv_b !== 1'b1) $display("FAIL oor_preload got f=%h fv=%b want 5a/1", f_b, fv_b); else pass_cnt++;
        s = 3'd7;
        #1;
        total++; if (ack_b !== 6'h00 || sel_b !== 3'd7) $display("FAIL oor_ack got ack=%h sel=%0d want 00/7", ack_b, sel_b); else pass_cnt++;
        @(negedge Clock);
        total++; if (f_b !== 8'h5A || fv_b !== 1'b1) $display("FAIL oor_hold got f=%h fv=%b want 5a/1", f_b, fv_b); else pass_cnt++;
        fr = 1'b1;
        #1;
        total++; if (ack_b !== 6'h00) $display("FAIL oor_ack_fr got %h want 00", ack_b); else pass_cnt++;
        @(negedge Clock);
        total++; if (fv_b !== 1'b0 || f_b !== 8'h5A) $display("FAIL oor_drain got f=%h fv=%b want 5a/0", f_b, fv_b); else pass_cnt++;
        wv_b = 6'h00;
    endtask

    task automatic test_mode_handoff;
        mode = 1'b0; s = 3'd3; wv = 8'h00; fr = 1'b1;
        repeat (2) @(negedge Clock);
        mode = 1'b1; s = 3'd0; wv = 8'h08; w[3*8 +: 8] = 8'h33;
        #1;
        total++; if (sel !== 3'd3 || ack !== 8'h08) $display("FAIL handoff got sel=%0d ack=%h want 3/08", sel, ack); else pass_cnt++;
        @(negedge Clock);
        total++; if (f !== 8'h33 || sel !== 3'd4) $display("FAIL handoff_load got f=%h sel=%0d want 33/4", f, sel); else pass_cnt++;
        En = 1'b0; wv = 8'hFF;
        for (int i = 0; i < 2; i++) begin
            #1;
            total++; if (ack !== 8'h00 || sel !== 3'd4) $display("FAIL en_off[%0d] got ack=%h sel=%0d want 00/4", i, ack, sel); else pass_cnt++;
            @(negedge Clock);
        end
        total++; if (sel !== 3'd4 || fv !== 1'b0 || f !== 8'h33) $display("FAIL en_off_end got sel=%0d fv=%b f=%h want 4/0/33", sel, fv, f); else pass_cnt++;
        En = 1'b1; wv = 8'h00;
    endtask

    task automatic test_async_reset;
        mode = 1'b0; s = 3'd1; wv = 8'h02; w[1*8 +: 8] = 8'h77; fr = 1'b0;
        @(negedge Clock);
        total++; if (f !== 8'h77 || fv !== 1'b1) $display("FAIL ar_preload got f=%h fv=%b want 77/1", f, fv); else pass_cnt++;
        mode = 1'b1;
        #2 Resetn = 1'b0;
        #1;
        total++; if (f !== 8'h00 || fv !== 1'b0) $display("FAIL ar_clear got f=%h fv=%b want 00/0", f, fv); else pass_cnt++;
        total++; if (sel !== 3'd0 || ack !== 8'h00) $display("FAIL ar_ptr got sel=%0d ack=%h want 0/00", sel, ack); else pass_cnt++;
        @(negedge Clock); Resetn = 1'b1;
        #1;
        total++; if (sel !== 3'd0 || ack !== 8'h00 || fv !== 1'b0) $display("FAIL ar_release got sel=%0d ack=%h fv=%b want 0/00/0", sel, ack, fv); else pass_cnt++;
    endtask

    initial begin
        test_reset;
        test_manual;
        test_backpressure;
        test_auto_wrap;
        test_out_of_range;
        test_mode_handoff;
        test_async_reset;
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
